multi_alarm_clock_core: RTL and testbench
=========================================

Name: multi_alarm_clock_core

Overview:
Parametrised time-keeping and alarm core that replaces the single-alarm clock logic and timing generator pair with one block. It runs directly on the board clock and derives the 1 s tick internally. It keeps time in 24 h form, holds NUM_ALARMS independently programmable alarms, and provides snooze, dismiss and timeout. It sits between keypad_logic (load requests) and lcd_display (hours/mins/am_pm).

Parameters:
CLK_HZ, 256, board clock cycles per second; the tick fires on count CLK_HZ-1.
NUM_ALARMS, 4, number of alarm slots (1..8).
IDX_W, 2, alarm index width; must be at least clog2(NUM_ALARMS), minimum 1.
SNOOZE_MINS, 9, snooze length in minutes (1..59).
ALARM_TIMEOUT_SECS, 60, ring duration before auto-stop (1..255).

Ports:
clk_256Hz  in  1  board clock; single clock domain.
reset  in  1  synchronous, active-high; all state is cleared on the clock edge while high.
load_time  in  1  one-cycle strobe: load set_hours/set_mins and zero the seconds.
load_alarm  in  1  one-cycle strobe: load set_hours/set_mins into slot alarm_sel.
alarm_sel  in  IDX_W  target slot for load_alarm.
set_hours  in  5  0..23, 24 h.
set_mins  in  6  0..59.
alarm_enable  in  NUM_ALARMS  per-slot enable switches.
snooze  in  1  one-cycle strobe.
dismiss  in  1  one-cycle strobe.
mode_24h  in  1  display format select.
hours  out  5  display hours: 1..12, or 0..23 when mode_24h=1.
mins  out  6  current minutes.
secs  out  6  current seconds.
am_pm  out  1  1 = PM (internal hour >= 12), valid in both modes.
alarm  out  1  high while ringing.
ring_idx  out  IDX_W  slot currently ringing or snoozed.
tick_1Hz  out  1  one-cycle pulse per second.
load_err  out  1  one-cycle pulse when a load is rejected.
chime  out  1  see Optional Feature.

Behaviour:
- Reset values:
  - Time 00:00:00, prescaler 0, all alarm slots 00:00.
  - State IDLE, ring_idx 0, fired[] all ones (no power-on ring).
  - Outputs: hours=12 (or 0 if mode_24h), mins=0, secs=0, am_pm=0, alarm=0, tick_1Hz=0, load_err=0, chime=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - tick_1Hz is a registered pulse asserted in the cycle after the count reaches CLK_HZ-1.
  - Time advances on tick: secs 59->0 increments mins; mins 59->0 increments hours; hours 23->0.
- load_time:
  - Valid load (hours<=23, mins<=59): time = set values, secs=0, prescaler=0 in the same edge. load_time overrides a coincident tick.
  - Invalid load: time unchanged, load_err pulses for 1 cycle.
- load_alarm:
  - Same validity rule. A valid load writes the slot and clears fired[sel].
  - alarm_sel >= NUM_ALARMS is rejected and pulses load_err.
  - Simultaneous load_time and load_alarm: both execute with the same values.
- Match: match[k] = alarm_enable[k] & (slot_k hh:mm == current hh:mm) & !fired[k].
- fired[k] clears in any cycle where slot_k hh:mm != current hh:mm.
- State machine:
  - IDLE: if any match, go to RINGING with ring_idx = lowest matching k; set fired[k]; load timeout counter = ALARM_TIMEOUT_SECS.
  - RINGING: alarm=1. Decrement timeout on tick.
    - dismiss -> IDLE.
    - snooze -> SNOOZED with snooze counter = SNOOZE_MINS*60.
    - timeout reaching 0 -> IDLE.
    - alarm_enable[ring_idx]=0 -> IDLE.
    - dismiss and snooze in the same cycle: dismiss wins.
  - SNOOZED: alarm=0. Decrement the snooze counter on tick.
    - Counter reaching 0 -> RINGING, timeout reloaded.
    - dismiss or alarm_enable[ring_idx]=0 -> IDLE.
    - snooze is ignored.
  - Matches on other slots while RINGING or SNOOZED are not latched. They fire on return to IDLE only if still matching and not yet fired.
- Reset mid-ring returns to IDLE within 1 cycle, and alarm drops to 0.
- Display conversion is combinational from the time registers:
  - 12 h mode: internal hour 0 -> 12; hours 13..23 -> h-12.
  - mode_24h can change at any time without affecting time keeping.

Optional Feature:
HOURLY_CHIME_EN
- Defined: chime is high for exactly 1 s (CLK_HZ cycles) starting at each mm:ss = 00:00 reached by a tick. A load_time to xx:00 does not chime. chime is suppressed while alarm=1.
- Undefined: chime is tied to 0 and no chime logic is built.

Decomposition:
- Package alarm_clock_pkg holds:
  - State enum {IDLE, RINGING, SNOOZED}.
  - Constants MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
  - A 12/24 h conversion function.
- One sub-module, time_counter_hms: prescaler, tick generation, hh:mm:ss counter, load handling.
- Alarm slots, match logic and the state machine stay in the top of this block.

Test Plan (CLK_HZ=4 to shorten runs):
- Reset; load_time 23:59, secs run 59 -> 00:00:00 -> hours=12, am_pm=0; mode_24h=1 -> hours=0.
- Slot 2 = 07:30 and slot 1 = 07:30, both enabled; time 07:29:59 -> tick -> alarm=1, ring_idx=1; dismiss -> alarm=0; slot 2 then rings the next cycle.
- Ringing; snooze (SNOOZE_MINS=1) -> alarm=0 for 60 ticks, then alarm=1 again; no action -> alarm=0 after ALARM_TIMEOUT_SECS ticks.
- Snooze and dismiss in the same cycle -> IDLE; ringing dismissed -> no re-ring within the same minute; re-ring next day at 07:30.
- load_time hours=24 -> load_err=1 for 1 cycle, time unchanged; load_alarm with alarm_sel=NUM_ALARMS (when less than 2^IDX_W) -> load_err=1.
- With HOURLY_CHIME_EN: 09:59:59 -> tick -> chime high for 4 cycles; without the macro, chime stays 0.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// =====================================================================
// alarm_clock_pkg : shared state encoding, time limits and 12/24 h
//                   display conversion for the alarm clock core.
// Revision: 1.0
// =====================================================================
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  function automatic logic [4:0] to_display_hours(input logic [4:0] h, input logic mode_24h);
    logic [4:0] d;
    d = h;
    if (!mode_24h) begin
      if (h == 5'd0)       d = 5'd12;
      else if (h > 5'd12)  d = h - 5'd12;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_core_time_counter_hms.sv
`default_nettype none
// =====================================================================
// time_counter_hms : board-clock prescaler, 1 Hz tick and 24 h
//                    hh:mm:ss counter with synchronous time load.
// Revision: 1.0
// =====================================================================
module time_counter_hms
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_mins,
  output logic       tick,
  output logic [4:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PRESC_MAX);

  // A load restarts the second from zero and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
      hours <= '0;
      mins  <= '0;
      secs  <= '0;
    end else if (load) begin
      presc <= '0;
      tick  <= 1'b0;
      hours <= set_hours;
      mins  <= set_mins;
      secs  <= '0;
    end else begin
      tick  <= wrap;
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap) begin
        if (secs == MAX_SEC) begin
          secs <= '0;
          if (mins == MAX_MIN) begin
            mins  <= '0;
            hours <= (hours == MAX_HOUR) ? '0 : hours + 1'b1;
          end else begin
            mins <= mins + 1'b1;
          end
        end else begin
          secs <= secs + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock_core.sv
`default_nettype none
// =====================================================================
// multi_alarm_clock_core : time keeping with NUM_ALARMS programmable
//   alarms, snooze, dismiss and ring timeout.
//   Optional macro HOURLY_CHIME_EN builds the top-of-hour chime.
// Revision: 1.0
// =====================================================================
module multi_alarm_clock_core
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ             = 256,
  parameter int NUM_ALARMS         = 4,
  parameter int IDX_W              = 2,
  parameter int SNOOZE_MINS        = 9,
  parameter int ALARM_TIMEOUT_SECS = 60
) (
  input  logic                  clk_256Hz,
  input  logic                  reset,
  input  logic                  load_time,
  input  logic                  load_alarm,
  input  logic [IDX_W-1:0]      alarm_sel,
  input  logic [4:0]            set_hours,
  input  logic [5:0]            set_mins,
  input  logic [NUM_ALARMS-1:0] alarm_enable,
  input  logic                  snooze,
  input  logic                  dismiss,
  input  logic                  mode_24h,
  output logic [4:0]            hours,
  output logic [5:0]            mins,
  output logic [5:0]            secs,
  output logic                  am_pm,
  output logic                  alarm,
  output logic [IDX_W-1:0]      ring_idx,
  output logic                  tick_1Hz,
  output logic                  load_err,
  output logic                  chime
);

  localparam int SLOT_SPAN = 1 << IDX_W;
  localparam logic [IDX_W:0] NUM_SLOTS = (IDX_W + 1)'(NUM_ALARMS);
  localparam logic [7:0]  TMO_LOAD = 8'(ALARM_TIMEOUT_SECS);
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MINS * 60);

  logic [4:0] cur_hours;
  logic       set_valid, sel_valid, time_load, alarm_load;

  assign set_valid  = (set_hours <= MAX_HOUR) && (set_mins <= MAX_MIN);
  assign sel_valid  = ({1'b0, alarm_sel} < NUM_SLOTS);
  assign time_load  = load_time & set_valid;
  assign alarm_load = load_alarm & set_valid & sel_valid;

  time_counter_hms #(.CLK_HZ(CLK_HZ)) u_time (
    .clk       (clk_256Hz),
    .reset     (reset),
    .load      (time_load),
    .set_hours (set_hours),
    .set_mins  (set_mins),
    .tick      (tick_1Hz),
    .hours     (cur_hours),
    .mins      (mins),
    .secs      (secs)
  );

  assign hours = to_display_hours(cur_hours, mode_24h);
  assign am_pm = (cur_hours >= 5'd12);

  logic [4:0]            slot_hours [NUM_ALARMS];
  logic [5:0]            slot_mins  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] fired, same_time, match;
  logic [SLOT_SPAN-1:0]  en_pad;
  logic                  any_match, ring_en, fire;
  logic [IDX_W-1:0]      first_idx, ring_idx_nx;

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_slot
    assign same_time[k] = (slot_hours[k] == cur_hours) && (slot_mins[k] == mins);
    assign match[k]     = alarm_enable[k] & same_time[k] & ~fired[k];
  end

  assign en_pad    = SLOT_SPAN'(alarm_enable);
  assign ring_en   = en_pad[ring_idx];
  assign any_match = |match;

  always_comb begin
    first_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (match[k]) first_idx = IDX_W'(k);
    end
  end

  // fired[] blocks a re-ring for the rest of the matching minute.
  always_ff @(posedge clk_256Hz) begin
    if (reset) begin
      fired <= '1;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        slot_hours[k] <= '0;
        slot_mins[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (!same_time[k])                  fired[k] <= 1'b0;
        if (fire && first_idx == IDX_W'(k)) fired[k] <= 1'b1;
        if (alarm_load && alarm_sel == IDX_W'(k)) begin
          fired[k]      <= 1'b0;
          slot_hours[k] <= set_hours;
          slot_mins[k]  <= set_mins;
        end
      end
    end
  end

  state_t      state, state_nx;
  logic [7:0]  tmo, tmo_nx;
  logic [11:0] snz, snz_nx;

  always_ff @(posedge clk_256Hz) begin
    if (reset) begin
      state    <= IDLE;
      tmo      <= '0;
      snz      <= '0;
      ring_idx <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      tmo      <= tmo_nx;
      snz      <= snz_nx;
      ring_idx <= ring_idx_nx;
      load_err <= (load_time & ~set_valid) | (load_alarm & ~(set_valid & sel_valid));
    end
  end

  always_comb begin
    state_nx    = state;
    tmo_nx      = tmo;
    snz_nx      = snz;
    ring_idx_nx = ring_idx;
    fire        = 1'b0;
    case (state)
      IDLE: begin
        if (any_match) begin
          fire        = 1'b1;
          state_nx    = RINGING;
          ring_idx_nx = first_idx;
          tmo_nx      = TMO_LOAD;
        end
      end
      RINGING: begin
        if (dismiss || !ring_en) begin
          state_nx = IDLE;
        end else if (snooze) begin
          state_nx = SNOOZED;
          snz_nx   = SNZ_LOAD;
        end else if (tick_1Hz) begin
          if (tmo <= 8'd1) state_nx = IDLE;
          else             tmo_nx   = tmo - 8'd1;
        end
      end
      SNOOZED: begin
        if (dismiss || !ring_en) begin
          state_nx = IDLE;
        end else if (tick_1Hz) begin
          if (snz <= 12'd1) begin
            state_nx = RINGING;
            tmo_nx   = TMO_LOAD;
          end else begin
            snz_nx = snz - 12'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign alarm = (state == RINGING);

`ifdef HOURLY_CHIME_EN
  localparam int CW = $clog2(CLK_HZ + 1) + 1;
  logic [CW-1:0] chime_cnt;
  logic          top_of_hour;

  // The tick cycle itself is the first of the CLK_HZ chime cycles.
  assign top_of_hour = tick_1Hz && (mins == 6'd0) && (secs == 6'd0);

  always_ff @(posedge clk_256Hz) begin
    if (reset)                 chime_cnt <= '0;
    else if (top_of_hour)      chime_cnt <= CW'(CLK_HZ - 1);
    else if (chime_cnt != '0)  chime_cnt <= chime_cnt - 1'b1;
  end

  assign chime = (top_of_hour || (chime_cnt != '0)) && !alarm;
`else
  assign chime = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock_core.sv
`default_nettype none
// =====================================================================
// tb_multi_alarm_clock_core : directed scenarios plus randomized traffic
//   checked every cycle against a seconds-of-day reference model.
// Revision: 1.0
// =====================================================================
module tb_multi_alarm_clock_core;

  localparam int CLK_HZ = 4;
  localparam int N      = 3;
  localparam int IW     = 2;
  localparam int SNZ    = 1;
  localparam int TO     = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_time, load_alarm, snooze, dismiss, mode_24h;
  logic [IW-1:0] alarm_sel;
  logic [4:0]    set_hours;
  logic [5:0]    set_mins;
  logic [N-1:0]  alarm_enable;
  logic [4:0]    hours;
  logic [5:0]    mins, secs;
  logic          am_pm, alarm, tick_1Hz, load_err, chime;
  logic [IW-1:0] ring_idx;

  multi_alarm_clock_core #(
    .CLK_HZ(CLK_HZ), .NUM_ALARMS(N), .IDX_W(IW),
    .SNOOZE_MINS(SNZ), .ALARM_TIMEOUT_SECS(TO)
  ) dut (
    .clk_256Hz(clk), .reset(reset), .load_time(load_time), .load_alarm(load_alarm),
    .alarm_sel(alarm_sel), .set_hours(set_hours), .set_mins(set_mins),
    .alarm_enable(alarm_enable), .snooze(snooze), .dismiss(dismiss), .mode_24h(mode_24h),
    .hours(hours), .mins(mins), .secs(secs), .am_pm(am_pm), .alarm(alarm),
    .ring_idx(ring_idx), .tick_1Hz(tick_1Hz), .load_err(load_err), .chime(chime)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarms as minute of day.
  int  m_tod, m_presc, m_st, m_ridx, m_tmo, m_snz, m_chime;
  bit  m_tick, m_err, mv;
  int  m_slot [N];
  bit  m_fired[N];

  always @(posedge clk) begin : model
    int  cur_min, fire_k, nm;
    bit  ok, ren;
    bit  same[N];
    if (reset) begin
      m_tod = 0; m_presc = 0; m_tick = 0; m_err = 0;
      m_st = 0; m_ridx = 0; m_tmo = 0; m_snz = 0; m_chime = 0;
      for (int k = 0; k < N; k++) begin m_slot[k] = 0; m_fired[k] = 1; end
      mv = 1;
    end else begin
      cur_min = m_tod / 60;
      ok = (set_hours < 24) && (set_mins < 60);
      for (int k = 0; k < N; k++) same[k] = (m_slot[k] == cur_min);
      ren = alarm_enable[m_ridx];
      fire_k = -1;
      if (m_st == 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (alarm_enable[k] && same[k] && !m_fired[k]) fire_k = k;
        if (fire_k >= 0) begin m_st = 1; m_ridx = fire_k; m_tmo = TO; end
      end else if (m_st == 1) begin
        if (dismiss || !ren) m_st = 0;
        else if (snooze) begin m_st = 2; m_snz = SNZ * 60; end
        else if (m_tick) begin m_tmo--; if (m_tmo == 0) m_st = 0; end
      end else begin
        if (dismiss || !ren) m_st = 0;
        else if (m_tick) begin
          m_snz--;
          if (m_snz == 0) begin m_st = 1; m_tmo = TO; end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!same[k]) m_fired[k] = 0;
        if (k == fire_k) m_fired[k] = 1;
      end
      if (load_alarm && ok && int'(alarm_sel) < N) begin
        m_slot[alarm_sel] = set_hours * 60 + set_mins;
        m_fired[alarm_sel] = 0;
      end
      m_err = (load_time && !ok) || (load_alarm && (!ok || int'(alarm_sel) >= N));
      if (load_time && ok) begin
        m_tod = set_hours * 3600 + set_mins * 60; m_presc = 0; m_tick = 0;
      end else begin
        nm = m_presc + 1;
        m_tick = (nm == CLK_HZ);
        m_presc = m_tick ? 0 : nm;
        if (m_tick) m_tod = (m_tod + 1) % 86400;
      end
      if (m_tick && (m_tod % 3600) == 0) m_chime = CLK_HZ;
      else if (m_chime > 0) m_chime--;
    end
  end

  always @(negedge clk) begin : compare
    int hh, eh, ec;
    if (mv) begin
      hh = m_tod / 3600;
      eh = mode_24h ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
`ifdef HOURLY_CHIME_EN
      ec = (m_chime > 0 && m_st != 1) ? 1 : 0;
`else
      ec = 0;
`endif
      chk("hours", int'(hours), eh);
      chk("mins", int'(mins), (m_tod / 60) % 60);
      chk("secs", int'(secs), m_tod % 60);
      chk("am_pm", int'(am_pm), (hh >= 12) ? 1 : 0);
      chk("alarm", int'(alarm), (m_st == 1) ? 1 : 0);
      chk("ring_idx", int'(ring_idx), m_ridx);
      chk("tick_1Hz", int'(tick_1Hz), int'(m_tick));
      chk("load_err", int'(load_err), int'(m_err));
      chk("chime", int'(chime), ec);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_time(input int h, input int m);
    set_hours = 5'(h); set_mins = 6'(m); load_time = 1'b1;
    cyc(1);
    load_time = 1'b0;
  endtask

  task automatic set_alarm(input int sel, input int h, input int m);
    alarm_sel = IW'(sel); set_hours = 5'(h); set_mins = 6'(m); load_alarm = 1'b1;
    cyc(1);
    load_alarm = 1'b0;
  endtask

  task automatic wait_alarm(input bit v, input int budget, input string name);
    int i;
    i = 0;
    while (alarm !== v && i < budget) begin cyc(1); i++; end
    chk(name, int'(alarm), int'(v));
  endtask

  initial begin : stim
    int n, i, exp_chime;
    reset = 1; load_time = 0; load_alarm = 0; snooze = 0; dismiss = 0; mode_24h = 0;
    alarm_sel = '0; set_hours = '0; set_mins = '0; alarm_enable = '0;
    cyc(3);
    chk("rst_hours", int'(hours), 12);
    chk("rst_mins", int'(mins), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_tick", int'(tick_1Hz), 0);
    reset = 0;

    set_time(23, 59);
    chk("pm_hours", int'(hours), 11);
    chk("pm_flag", int'(am_pm), 1);
    i = 0;
    while (mins != 0 && i < 300) begin cyc(1); i++; end
    chk("midnight_mins", int'(mins), 0);
    chk("midnight_hours12", int'(hours), 12);
    chk("midnight_am", int'(am_pm), 0);
    chk("midnight_secs", int'(secs), 0);
    mode_24h = 1; #1;
    chk("midnight_hours24", int'(hours), 0);
    mode_24h = 0;

    set_alarm(2, 7, 30);
    set_alarm(1, 7, 30);
    alarm_enable = 3'b110;
    set_time(7, 29);
    wait_alarm(1, 300, "ring_start");
    chk("ring_first_idx", int'(ring_idx), 1);
    chk("ring_mins", int'(mins), 30);
    dismiss = 1; cyc(1); dismiss = 0;
    chk("dismiss_drop", int'(alarm), 0);
    cyc(1);
    chk("second_slot_ring", int'(alarm), 1);
    chk("second_slot_idx", int'(ring_idx), 2);

    snooze = 1; cyc(1); snooze = 0;
    chk("snooze_drop", int'(alarm), 0);
    n = 0; i = 0;
    while (!alarm && i < 400) begin if (tick_1Hz) n++; cyc(1); i++; end
    chk("snooze_ticks", n, 60);
    chk("snooze_rering", int'(alarm), 1);
    n = 0; i = 0;
    while (alarm && i < 200) begin if (tick_1Hz) n++; cyc(1); i++; end
    chk("timeout_ticks", n, TO);

    alarm_enable = 3'b010;
    set_time(7, 29);
    wait_alarm(1, 300, "ring_again");
    snooze = 1; dismiss = 1; cyc(1); snooze = 0; dismiss = 0;
    chk("snz_dis_idle", int'(alarm), 0);
    n = 0; i = 0;
    while (mins == 30 && i < 300) begin if (alarm) n++; cyc(1); i++; end
    chk("no_rering_same_min", n, 0);
    set_time(7, 29);
    wait_alarm(1, 300, "next_day_ring");
    chk("next_day_idx", int'(ring_idx), 1);
    reset = 1; cyc(1); reset = 0;
    chk("reset_mid_ring", int'(alarm), 0);

    set_time(10, 20);
    set_hours = 5'd24; set_mins = 6'd5; load_time = 1; cyc(1); load_time = 0;
    chk("bad_hour_err", int'(load_err), 1);
    chk("bad_hour_keep_h", int'(hours), 10);
    chk("bad_hour_keep_m", int'(mins), 20);
    cyc(1);
    chk("err_one_cycle", int'(load_err), 0);
    set_alarm(3, 8, 0);
    chk("bad_sel_err", int'(load_err), 1);

`ifdef HOURLY_CHIME_EN
    exp_chime = CLK_HZ;
`else
    exp_chime = 0;
`endif
    set_time(9, 59);
    n = 0;
    for (int c = 0; c < 280; c++) begin if (chime) n++; cyc(1); end
    chk("chime_cycles", n, exp_chime);
    chk("chime_hour", int'(hours), 10);

    alarm_enable = 3'b111;
    for (int c = 0; c < 15000; c++) begin
      reset      = ($urandom_range(0, 2999) == 0);
      load_time  = ($urandom_range(0, 149) == 0);
      load_alarm = ($urandom_range(0, 149) == 0);
      snooze     = ($urandom_range(0, 59) == 0);
      dismiss    = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 99) == 0) mode_24h = ~mode_24h;
      if ($urandom_range(0, 199) == 0) alarm_enable = N'($urandom_range(0, 7));
      alarm_sel = IW'($urandom_range(0, 3));
      set_hours = ($urandom_range(0, 19) == 0) ? 5'd24 : 5'(7 + 2 * $urandom_range(0, 1));
      set_mins  = ($urandom_range(0, 19) == 0) ? 6'd60 : 6'(28 + $urandom_range(0, 3));
      cyc(1);
    end
    reset = 0; load_time = 0; load_alarm = 0; snooze = 0; dismiss = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
